// File: rtl/uma_pkg.sv
// uma_pkg: shared types and helpers for the unified-memory grant path.
//   uma_state_e   grant FSM state encoding
//   UMA_PORTS     number of requesters (16)
//   UMA_IDX_W     width of a requester index (4)
//   idx_from_enc  recovers the true index from the encoder's inverted output
package uma_pkg;

  localparam int UMA_PORTS = 16;
  localparam int UMA_IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } uma_state_e;

  function automatic logic [UMA_IDX_W-1:0] idx_from_enc(input logic [UMA_IDX_W-1:0] enc);
    return ~enc;
  endfunction

endpackage

// File: rtl/uma_onehot_dec.sv
// uma_onehot_dec: combinational 4-to-16 one-hot decoder.
//   idx     in   requester index
//   onehot  out  1 << idx
module uma_onehot_dec
  import uma_pkg::*;
(
  input  logic [UMA_IDX_W-1:0] idx,
  output logic [UMA_PORTS-1:0] onehot
);

  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/uma_grant_decoder.sv
// uma_grant_decoder: turns the priority encoder's index/valid into a held,
// registered one-hot grant for the unified-memory port mux, and freezes the
// encoder (enc_enable_n=1) while a grant is outstanding.
//
// Optional feature macro: UMA_GRANT_TIMEOUT_EN
//   defined   - grant is force-released after MAX_HOLD cycles, preempt pulses
//   undefined - grant held until the request drops, preempt tied to 0
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   synchronous active-high reset
//   req           in   live request vector, bit 0 highest priority
//   enc_result    in   encoder output, inverted index
//   enc_valid     in   encoder found a request while enabled
//   enc_enable_n  out  active-low encoder enable, 0 only while idle
//   grant         out  registered one-hot grant
//   grant_idx     out  index of the current grant, 0 when none
//   grant_valid   out  |grant
//   stale_cnt     out  saturating count of rejected stale encodings
//   preempt       out  one-cycle pulse when a grant ends by timeout
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no grant; encoder enabled from the second IDLE cycle onward
// HOLD  | grant active while the winner keeps requesting
// GAP   | one grant-free turnaround cycle for the port mux
module uma_grant_decoder
  import uma_pkg::*;
#(
  parameter int MAX_HOLD = 64,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [UMA_PORTS-1:0] req,
  input  logic [UMA_IDX_W-1:0] enc_result,
  input  logic                 enc_valid,
  output logic                 enc_enable_n,
  output logic [UMA_PORTS-1:0] grant,
  output logic [UMA_IDX_W-1:0] grant_idx,
  output logic                 grant_valid,
  output logic [7:0]           stale_cnt,
  output logic                 preempt
);

  if ((MAX_HOLD < 2) || (MAX_HOLD > 65535) || (MAX_HOLD >= (1 << CNT_W))) begin : g_bad_param
    $error("uma_grant_decoder: MAX_HOLD out of range for CNT_W");
  end

  uma_state_e           state;
  logic [UMA_IDX_W-1:0] enc_idx;
  logic [UMA_PORTS-1:0] enc_onehot;
  logic                 sample;
  logic                 enc_hit;
  logic                 held;

  assign enc_idx = idx_from_enc(enc_result);

  uma_onehot_dec u_dec (
    .idx    (enc_idx),
    .onehot (enc_onehot)
  );

  // The encoder output is only meaningful once enc_enable_n has actually
  // been low for a cycle, so the first IDLE cycle after GAP never samples.
  assign sample  = (state == IDLE) && !enc_enable_n && enc_valid;
  assign enc_hit = |(enc_onehot & req);
  assign held    = |(grant & req);

`ifdef UMA_GRANT_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt;
  logic             hold_tc;

  assign hold_tc = (hold_cnt == CNT_W'(MAX_HOLD));
`else
  assign preempt = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      grant        <= '0;
      grant_idx    <= '0;
      grant_valid  <= 1'b0;
      enc_enable_n <= 1'b1;
      stale_cnt    <= '0;
`ifdef UMA_GRANT_TIMEOUT_EN
      hold_cnt     <= '0;
      preempt      <= 1'b0;
`endif
    end else begin
`ifdef UMA_GRANT_TIMEOUT_EN
      preempt <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (sample && enc_hit) begin
            state        <= HOLD;
            grant        <= enc_onehot;
            grant_idx    <= enc_idx;
            grant_valid  <= 1'b1;
            enc_enable_n <= 1'b1;
`ifdef UMA_GRANT_TIMEOUT_EN
            hold_cnt     <= CNT_W'(1);
`endif
          end else begin
            enc_enable_n <= 1'b0;
            if (sample && (stale_cnt != 8'hFF)) begin
              stale_cnt <= stale_cnt + 8'd1;
            end
          end
        end
        HOLD: begin
          enc_enable_n <= 1'b1;
          // A request drop wins over a simultaneous timeout: no preempt.
          if (!held) begin
            state       <= GAP;
            grant       <= '0;
            grant_valid <= 1'b0;
          end
`ifdef UMA_GRANT_TIMEOUT_EN
          else if (hold_tc) begin
            state       <= GAP;
            grant       <= '0;
            grant_valid <= 1'b0;
            preempt     <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
`endif
        end
        GAP: begin
          state        <= IDLE;
          grant_idx    <= '0;
          enc_enable_n <= 1'b1;
        end
        default: begin
          state        <= IDLE;
          grant        <= '0;
          grant_idx    <= '0;
          grant_valid  <= 1'b0;
          enc_enable_n <= 1'b1;
        end
      endcase
    end
  end

  a_grant_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(grant));

endmodule

// File: tb/tb_uma_grant_decoder.sv
// tb_uma_grant_decoder: directed-vector bench for uma_grant_decoder.
// Inputs change 1 time unit after the rising edge; outputs are checked there.
// Build with UMA_GRANT_TIMEOUT_EN defined to exercise the timeout (MAX_HOLD=4).
module tb_uma_grant_decoder;

`ifdef UMA_GRANT_TIMEOUT_EN
  localparam int TB_MAX_HOLD = 4;
`else
  localparam int TB_MAX_HOLD = 64;
`endif

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic [3:0]  enc_result;
  logic        enc_valid;
  logic        enc_enable_n;
  logic [15:0] grant;
  logic [3:0]  grant_idx;
  logic        grant_valid;
  logic [7:0]  stale_cnt;
  logic        preempt;

  int n_vec = 0;
  int n_err = 0;

  uma_grant_decoder #(
    .MAX_HOLD (TB_MAX_HOLD),
    .CNT_W    (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .enc_result   (enc_result),
    .enc_valid    (enc_valid),
    .enc_enable_n (enc_enable_n),
    .grant        (grant),
    .grant_idx    (grant_idx),
    .grant_valid  (grant_valid),
    .stale_cnt    (stale_cnt),
    .preempt      (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From HOLD: drop request, then GAP, IDLE(disabled), IDLE(enabled).
  task automatic back_to_idle();
    req        = '0;
    enc_valid  = 1'b0;
    enc_result = 4'hF;
    tick();
    tick();
    tick();
  endtask

  initial begin
    rst        = 1'b1;
    req        = '0;
    enc_result = 4'hF;
    enc_valid  = 1'b0;
    tick();
    tick();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_idx", 32'(grant_idx), 32'h0);
    chk("rst_gv", 32'(grant_valid), 32'h0);
    chk("rst_en_n", 32'(enc_enable_n), 32'h1);
    chk("rst_stale", 32'(stale_cnt), 32'h0);
    chk("rst_preempt", 32'(preempt), 32'h0);

    rst = 1'b0;
    tick();
    chk("post_rst_en_n", 32'(enc_enable_n), 32'h0);

    // Single request on index 4, held 5 grant cycles.
    req        = 16'h0010;
    enc_result = 4'hB;
    enc_valid  = 1'b1;
    tick();
    chk("single_grant", 32'(grant), 32'h0010);
    chk("single_idx", 32'(grant_idx), 32'h4);
    chk("single_gv", 32'(grant_valid), 32'h1);
    chk("single_en_n", 32'(enc_enable_n), 32'h1);
    enc_result = 4'hF;
    enc_valid  = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("single_hold5", 32'(grant), 32'h0010);
    req = '0;
    tick();
    chk("single_rel_grant", 32'(grant), 32'h0);
    chk("single_rel_gv", 32'(grant_valid), 32'h0);
    chk("single_gap_idx", 32'(grant_idx), 32'h4);
    tick();
    chk("single_idle_idx", 32'(grant_idx), 32'h0);
    chk("single_idle1_en_n", 32'(enc_enable_n), 32'h1);
    tick();
    chk("single_idle2_en_n", 32'(enc_enable_n), 32'h0);

    // Back-to-back same requester: three grant-free cycles.
    req        = 16'h0010;
    enc_result = 4'hB;
    enc_valid  = 1'b1;
    tick();
    chk("b2b_first", 32'(grant), 32'h0010);
    req = '0;
    tick();
    chk("b2b_zero1", 32'(grant), 32'h0);
    req = 16'h0010;
    tick();
    chk("b2b_zero2", 32'(grant), 32'h0);
    tick();
    chk("b2b_zero3", 32'(grant), 32'h0);
    tick();
    chk("b2b_regrant", 32'(grant), 32'h0010);
    back_to_idle();
    chk("b2b_idle_en_n", 32'(enc_enable_n), 32'h0);

    // Stale encodings: index 2 with no request.
    req        = '0;
    enc_result = 4'hD;
    enc_valid  = 1'b1;
    tick();
    chk("stale_first", 32'(stale_cnt), 32'h1);
    chk("stale_no_grant", 32'(grant), 32'h0);
    for (int i = 1; i < 254; i++) tick();
    chk("stale_254", 32'(stale_cnt), 32'd254);
    for (int i = 254; i < 300; i++) tick();
    chk("stale_sat", 32'(stale_cnt), 32'd255);
    chk("stale_sat_en_n", 32'(enc_enable_n), 32'h0);

    // No preemption by a higher-priority request.
    req        = 16'h0080;
    enc_result = 4'h8;
    enc_valid  = 1'b1;
    tick();
    chk("nopre_grant", 32'(grant), 32'h0080);
    chk("nopre_idx", 32'(grant_idx), 32'h7);
    req        = 16'h0081;
    enc_result = 4'hF;
    for (int i = 0; i < 3; i++) tick();
    chk("nopre_held", 32'(grant), 32'h0080);
    chk("nopre_stale_same", 32'(stale_cnt), 32'd255);
    req = 16'h0001;
    tick();
    chk("nopre_release", 32'(grant), 32'h0);
    back_to_idle();

`ifdef UMA_GRANT_TIMEOUT_EN
    // Timeout: grant lasts exactly MAX_HOLD=4 cycles, then preempt.
    req        = 16'h0008;
    enc_result = 4'hC;
    enc_valid  = 1'b1;
    tick();
    chk("to_grant_c1", 32'(grant), 32'h0008);
    tick();
    tick();
    tick();
    chk("to_grant_c4", 32'(grant), 32'h0008);
    chk("to_no_preempt_c4", 32'(preempt), 32'h0);
    tick();
    chk("to_release", 32'(grant), 32'h0);
    chk("to_preempt", 32'(preempt), 32'h1);
    tick();
    chk("to_preempt_pulse", 32'(preempt), 32'h0);
    chk("to_zero2", 32'(grant), 32'h0);
    tick();
    chk("to_zero3", 32'(grant), 32'h0);
    tick();
    chk("to_regrant", 32'(grant), 32'h0008);
    // Release in the same cycle the counter reaches 4.
    tick();
    tick();
    tick();
    req       = '0;
    enc_valid = 1'b0;
    tick();
    chk("coinc_release", 32'(grant), 32'h0);
    chk("coinc_preempt", 32'(preempt), 32'h0);
    back_to_idle();
`else
    // Without the timeout a grant outlives MAX_HOLD.
    req        = 16'h0008;
    enc_result = 4'hC;
    enc_valid  = 1'b1;
    tick();
    chk("long_grant", 32'(grant), 32'h0008);
    enc_valid = 1'b0;
    for (int i = 0; i < 70; i++) tick();
    chk("long_held", 32'(grant), 32'h0008);
    chk("long_preempt", 32'(preempt), 32'h0);
    back_to_idle();
`endif

    // Reset in the middle of a grant to index 15.
    req        = 16'h8000;
    enc_result = 4'h0;
    enc_valid  = 1'b1;
    tick();
    chk("rmid_grant", 32'(grant), 32'h8000);
    chk("rmid_idx", 32'(grant_idx), 32'hF);
    enc_valid = 1'b0;
    rst       = 1'b1;
    tick();
    chk("rmid_grant_rst", 32'(grant), 32'h0);
    chk("rmid_idx_rst", 32'(grant_idx), 32'h0);
    chk("rmid_gv_rst", 32'(grant_valid), 32'h0);
    chk("rmid_en_n_rst", 32'(enc_enable_n), 32'h1);
    chk("rmid_stale_rst", 32'(stale_cnt), 32'h0);
    rst = 1'b0;
    tick();
    chk("rmid_en_n_after", 32'(enc_enable_n), 32'h0);
    chk("rmid_no_gap", 32'(grant), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uma_grant_decoder.md
Name: uma_grant_decoder

Overview:
- Back end of the memory-arbiter request path; consumes the 16-way priority encoder's index/valid output.
- Decodes the index into a registered one-hot grant and holds it while the winning requester keeps its request asserted.
- Drives the encoder's active-low enable, so arbitration is frozen during a grant.
- Sits between the encoder and the unified-memory port mux.

Parameters:
- MAX_HOLD, 64: maximum consecutive grant cycles before forced release (used only with the optional feature); legal range 2..65535.
- CNT_W, 16: width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req  in  16  live request vector; bit 0 is highest priority
- enc_result  in  4  encoder output, bit-inverted index (index = ~enc_result); reads 4'hF when disabled
- enc_valid  in  1  encoder found a request while enabled
- enc_enable_n  out  1  active-low enable to the encoder; 0 only in IDLE
- grant  out  16  registered one-hot grant; all zero when no grant
- grant_idx  out  4  true (non-inverted) index of the current grant; 0 when none
- grant_valid  out  1  a grant is active (equals |grant)
- stale_cnt  out  8  saturating count of rejected stale encodings
- preempt  out  1  one-cycle pulse when a grant ends by timeout

Behaviour:
- Reset values: grant=0, grant_idx=0, grant_valid=0, enc_enable_n=1, stale_cnt=0, preempt=0, hold counter=0, state=IDLE.
- enc_enable_n is a registered output: 0 in IDLE, 1 in every other state, so the encoder is enabled one cycle after entering IDLE.
- State machine: IDLE -> HOLD -> GAP -> IDLE.
- IDLE:
  - Sample enc_valid. Let i = ~enc_result.
  - If enc_valid=1 and req[i]=1: next cycle grant=1<<i, grant_idx=i, grant_valid=1, counter=1, state=HOLD.
  - If enc_valid=1 and req[i]=0 (stale): stale_cnt increments, saturating at 255; stay in IDLE.
  - If enc_valid=0: stay in IDLE.
  - Latency from a valid encoding to grant: 1 cycle.
- HOLD:
  - If req[grant_idx]=0: release. Next cycle grant=0, grant_valid=0, state=GAP.
  - Otherwise the counter increments.
  - Other req bits changing during HOLD have no effect; there is no preemption by a higher-priority request.
- GAP:
  - Exactly one idle cycle with grant=0 for port-mux turnaround, then IDLE.
  - enc_result and enc_valid are ignored in GAP.
- grant_idx keeps its last value through GAP and returns to 0 when IDLE is entered.
- Simultaneous release and timeout in the same cycle: treated as a normal release; preempt stays 0.
- Reset mid-grant: grant drops to 0 on the next edge; no GAP cycle is inserted.
- Width rules:
  - Only 4'hF..4'h0 encodings exist, so every index is in range.
  - grant is always one-hot or zero; an assertion checks $onehot0(grant).
- Back-to-back requester: minimum period between two grants to the same requester is HOLD end, then GAP, then IDLE (re-enable), then sample. That is 3 cycles of grant=0.

Optional Feature:
- Macro: UMA_GRANT_TIMEOUT_EN.
- Defined:
  - In HOLD, when the counter reaches MAX_HOLD while req[grant_idx] is still 1, the grant is force-released: state goes to GAP and preempt pulses 1 in the same cycle grant drops.
  - The counter saturates and does not wrap.
- Undefined:
  - Counter and compare logic are removed; a grant is held until the request drops.
  - preempt is tied to 0.
  - MAX_HOLD and CNT_W are unused.

Decomposition:
- Shared package uma_pkg holds:
  - state enum (IDLE=2'd0, HOLD=2'd1, GAP=2'd2)
  - UMA_PORTS=16, UMA_IDX_W=4
  - function idx_from_enc(enc) returning ~enc
- One sub-module, uma_onehot_dec: a purely combinational 4-to-16 decoder used for the grant next-state. The FSM, counter and stale counter stay in the top level.

Test Plan:
- Single request: req=16'h0010, enc_result=4'hB, enc_valid=1 in IDLE -> next cycle grant=16'h0010, grant_idx=4, enc_enable_n=1; drop req after 5 cycles -> grant=0 next cycle, then one GAP cycle, then enc_enable_n=0.
- Stale encoding: enc_valid=1, enc_result=4'hD (index 2), req=0 -> no grant, stale_cnt 0->1; repeat 300 times -> stale_cnt=255.
- No preemption: grant held on index 7, then req[0] rises -> grant stays 16'h0080 until req[7] falls.
- Timeout (UMA_GRANT_TIMEOUT_EN, MAX_HOLD=4): req[3] held high -> grant high for exactly 4 cycles, preempt=1 on the release edge, re-grant to index 3 three cycles later.
- Release coinciding with timeout (MAX_HOLD=4): req[3] drops in the cycle the counter reaches 4 -> grant drops, preempt=0.
- Reset mid-HOLD: rst=1 while grant=16'h8000 -> next edge all outputs at reset values; after rst=0, enc_enable_n=0 in the first cycle.
